dma_cfg_sched: RTL
==================

DMA_CFG_SCHED -- requirements
Module: dma_cfg_sched

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 1024, max cycles to wait for lite_end per register write (>=2).
REQ-002 Parameter: CR_VALUE, 32'h0000_1001, data written to the channel control register (run + IOC irq enable).
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 ch0_req_valid  in  1  MM2S transfer request.
REQ-006 ch0_req_ready  out  1  MM2S request accepted when valid&ready.
REQ-007 ch0_addr  in  32  MM2S source address.
REQ-008 ch0_len  in  26  MM2S byte length.
REQ-009 ch1_req_valid / ch1_req_ready / ch1_addr / ch1_len  in/out/in/in  1/1/32/26  S2MM equivalents (destination address).
REQ-010 lite_awaddr  out  10  register address to the AXI-lite write master.
REQ-011 lite_wdata  out  32  register data to the AXI-lite write master.
REQ-012 lite_valid  out  1  one-cycle pulse starting one register write.
REQ-013 lite_end  in  1  one-cycle pulse: register write complete.
REQ-014 ch0_done, ch1_done  out  1 each  one-cycle pulse: channel fully programmed.
REQ-015 ch0_err, ch1_err  out  1 each  one-cycle pulse: request rejected or timed out.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 prog_count  out  16  count of successfully programmed requests.

Function
REQ-018 States: IDLE, ISSUE, WAIT, DONE; one request in flight at a time.
REQ-019 Round-robin: in IDLE, single valid requester wins; both valid -> channel other than last_grant wins.
REQ-020 chN_req_ready high only in IDLE, combinationally, for the winning channel only; never both.
REQ-021 On handshake: latch channel, addr, len; update last_grant; write index=0; IDLE->ISSUE.
REQ-022 chN_len==0 on handshake: no writes; chN_err pulses next cycle; stay IDLE; last_grant still updated.
REQ-023 Write order ch0: (0x000, CR_VALUE), (0x018, addr), (0x028, {6'b0,len}).
REQ-024 Write order ch1: (0x030, CR_VALUE), (0x048, addr), (0x058, {6'b0,len}).
REQ-025 ISSUE: lite_valid=1 for exactly one cycle; ->WAIT; watchdog cleared.
REQ-026 lite_awaddr/lite_wdata valid in ISSUE, held stable through WAIT until lite_end is sampled.
REQ-027 WAIT, lite_end=1: index<2 -> index+1, ->ISSUE; index==2 -> DONE.
REQ-028 DONE: chN_done=1 one cycle; prog_count+1 (wraps 0xFFFF->0x0000); ->IDLE.
REQ-029 WAIT, watchdog reaches TIMEOUT_CYCLES-1 without lite_end: chN_err pulse, ->IDLE, no done, no count.
REQ-030 lite_end outside WAIT ignored.
REQ-031 lite_end and timeout same cycle: lite_end wins.
REQ-032 Latency: handshake at cycle T -> first lite_valid at T+1; third lite_end at E -> chN_done at E+1, ready possible at E+2.
REQ-033 Latched addr/len unaffected by input changes after handshake.

Reset
REQ-034 rst: state=IDLE, last_grant=ch1 (ch0 wins first tie), index=0, watchdog=0, prog_count=0.
REQ-035 Outputs in reset: lite_valid=0, lite_awaddr=0, lite_wdata=0, all ready/done/err=0, busy=0.
REQ-036 rst mid-sequence aborts without done or err; first cycle after reset is IDLE.

Verification
REQ-037 ch0 req addr=0x1000_0000 len=0x400, lite_end 3 cycles after each lite_valid -> writes (0x000,0x1001),(0x018,0x1000_0000),(0x028,0x400); ch0_done once; prog_count=1.
REQ-038 Both valid continuously from reset -> grants ch0,ch1,ch0,ch1; ch1 writes use 0x030/0x048/0x058.
REQ-039 ch1 len=0 -> ch1_req_ready handshake, ch1_err one pulse, no lite_valid, prog_count unchanged.
REQ-040 lite_end withheld after second write, TIMEOUT_CYCLES=16 -> ch0_err 16 cycles after lite_valid; IDLE; late lite_end ignored.
REQ-041 rst asserted during WAIT of write 2 -> all outputs 0 next cycle; new request then runs full 3-write sequence.
REQ-042 Preload 65535 completions -> next done wraps prog_count to 0x0000.

Source files
------------

// File: rtl/dma_cfg_sched.sv
// dma_cfg_sched: arbitrates two DMA channel requests (MM2S = ch0, S2MM = ch1)
// round-robin and programs the winning channel's control, address and length
// registers through a single-outstanding AXI-lite write master.
//
// Handshakes: a request is accepted in the cycle where chN_req_valid and
// chN_req_ready are both high; ready is a combinational function of state and
// the valids, is only offered in IDLE, and never to both channels at once.
// lite_valid is a one-cycle start pulse; lite_awaddr/lite_wdata stay stable
// from that pulse until lite_end (one-cycle completion pulse) is sampled.
module dma_cfg_sched #(
  parameter int unsigned TIMEOUT_CYCLES   = 1024,
  parameter logic [31:0] CR_VALUE         = 32'h0000_1001,
  // Reset value of prog_count; left at zero except to exercise its wrap.
  parameter logic [15:0] PROG_COUNT_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ch0_req_valid,
  output logic        ch0_req_ready,
  input  logic [31:0] ch0_addr,
  input  logic [25:0] ch0_len,
  input  logic        ch1_req_valid,
  output logic        ch1_req_ready,
  input  logic [31:0] ch1_addr,
  input  logic [25:0] ch1_len,
  output logic [9:0]  lite_awaddr,
  output logic [31:0] lite_wdata,
  output logic        lite_valid,
  input  logic        lite_end,
  output logic        ch0_done,
  output logic        ch1_done,
  output logic        ch0_err,
  output logic        ch1_err,
  output logic        busy,
  output logic [15:0] prog_count,
  output logic [1:0]  state_dbg
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Watchdog value in the last WAIT cycle before the timeout takes effect.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t          state_q, state_d;
  logic            last_grant_q;   // 0 = ch0, 1 = ch1
  logic            cur_ch_q;
  logic [31:0]     addr_q;
  logic [25:0]     len_q;
  logic [1:0]      idx_q;
  logic [WD_W-1:0] wd_q;
  logic [15:0]     count_q;
  logic [1:0]      err_q;          // bit N = chN_err pulse

  logic            any_valid;
  logic            grant_ch;
  logic            hs;
  logic [25:0]     hs_len;
  logic [31:0]     hs_addr;
  logic            wd_last;

  // Arbitration: a lone requester wins; on a tie the channel not granted last wins.
  always_comb begin
    any_valid = ch0_req_valid | ch1_req_valid;
    grant_ch  = (ch0_req_valid && ch1_req_valid) ? ~last_grant_q : ch1_req_valid;
    hs        = (state_q == IDLE) && !rst && any_valid;
    hs_len    = grant_ch ? ch1_len  : ch0_len;
    hs_addr   = grant_ch ? ch1_addr : ch0_addr;
    wd_last   = (wd_q == WD_LAST);
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (hs && hs_len != 26'd0) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (lite_end)     state_d = (idx_q == 2'd2) ? DONE : ISSUE;
        else if (wd_last) state_d = IDLE;
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: register address/data come from the channel and write index.
  always_comb begin
    ch0_req_ready = hs && !grant_ch;
    ch1_req_ready = hs &&  grant_ch;
    lite_valid    = (state_q == ISSUE);
    busy          = (state_q != IDLE);
    ch0_done      = (state_q == DONE) && !cur_ch_q;
    ch1_done      = (state_q == DONE) &&  cur_ch_q;
    ch0_err       = err_q[0];
    ch1_err       = err_q[1];
    prog_count    = count_q;
    state_dbg     = state_q;
    lite_awaddr   = 10'h000;
    lite_wdata    = 32'h0000_0000;
    if (state_q == ISSUE || state_q == WAIT) begin
      case (idx_q)
        2'd0: begin
          lite_awaddr = cur_ch_q ? 10'h030 : 10'h000;
          lite_wdata  = CR_VALUE;
        end
        2'd1: begin
          lite_awaddr = cur_ch_q ? 10'h048 : 10'h018;
          lite_wdata  = addr_q;
        end
        default: begin
          lite_awaddr = cur_ch_q ? 10'h058 : 10'h028;
          lite_wdata  = {6'b0, len_q};
        end
      endcase
    end
  end

  // State register plus request latch, write index, watchdog, count and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cur_ch_q     <= 1'b0;
      addr_q       <= 32'h0;
      len_q        <= 26'h0;
      idx_q        <= 2'd0;
      wd_q         <= '0;
      count_q      <= PROG_COUNT_RESET;
      err_q        <= 2'b00;
    end else begin
      state_q <= state_d;
      err_q   <= 2'b00;
      case (state_q)
        IDLE: begin
          if (hs) begin
            last_grant_q <= grant_ch;
            if (hs_len == 26'd0) begin
              err_q[grant_ch] <= 1'b1;
            end else begin
              cur_ch_q <= grant_ch;
              addr_q   <= hs_addr;
              len_q    <= hs_len;
              idx_q    <= 2'd0;
            end
          end
        end
        ISSUE: wd_q <= '0;
        WAIT: begin
          if (lite_end) begin
            if (idx_q != 2'd2) idx_q <= idx_q + 2'd1;
          end else begin
            wd_q <= wd_q + 1'b1;
            if (wd_last) err_q[cur_ch_q] <= 1'b1;
          end
        end
        DONE: count_q <= count_q + 16'd1;
        default: ;
      endcase
    end
  end

endmodule
